// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain driver: controller state encoding
// and default chain / host-word geometry.
package ccff_pkg;

   localparam int CCFF_CHAIN_LEN_DEF = 160;
   localparam int CCFF_WORD_W_DEF    = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } ccff_state_e;

endpackage

// File: rtl/ccff_rb_packer.sv
// Readback packer: collects chain-tail bits MSB-first into host words and presents
// them on a valid/ready port; a flush emits a zero-padded partial word marked last.
module ccff_rb_packer
   import ccff_pkg::*;
#(
   parameter int WORD_W = CCFF_WORD_W_DEF
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              clear,
   input  logic              cap_en,
   input  logic              cap_bit,
   input  logic              cap_final,
   input  logic              flush,
   input  logic              m_ready,
   output logic              m_valid,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last
);

   localparam int                FILL_W    = $clog2(WORD_W);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WORD_W - 1);

   logic [WORD_W-1:0] sr;
   logic [FILL_W-1:0] fill;
   logic              out_free;

   assign out_free = !m_valid || m_ready;

   // Unfilled positions of sr stay 0, so a flushed partial word is already padded.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         sr      <= '0;
         fill    <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else if (clear) begin
         sr      <= '0;
         fill    <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else begin
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
         if (cap_en) begin
            if (fill == FILL_LAST) begin
               m_data  <= {sr[WORD_W-1:1], cap_bit};
               m_valid <= 1'b1;
               m_last  <= cap_final;
               sr      <= '0;
               fill    <= '0;
            end else begin
               sr[FILL_LAST - fill] <= cap_bit;
               fill                 <= fill + FILL_W'(1);
            end
         end else if (flush && (fill != '0) && out_free) begin
            m_data  <= sr;
            m_valid <= 1'b1;
            m_last  <= 1'b1;
            sr      <= '0;
            fill    <= '0;
         end
      end
   end

endmodule

// File: rtl/ccff_chain_driver.sv
// Configuration-chain driver: shifts host bitstream words into a ccff chain one bit
// per enabled prog_clk cycle while returning the chain's previous contents as words.
module ccff_chain_driver
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
   parameter int WORD_W    = CCFF_WORD_W_DEF
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_last,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_clk_en,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int               CNT_W   = $clog2(CHAIN_LEN + 1);
   localparam int               SH_W    = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);
   localparam logic [SH_W-1:0]  SH_MAX  = SH_W'(WORD_W);

   ccff_state_e       state, state_nxt;
   logic [CNT_W-1:0]  bitcnt, bitcnt_inc;
   logic [SH_W-1:0]   shcnt, shcnt_inc;
   logic [WORD_W-1:0] word_q;
   logic              last_q;

   logic start_ok, load_fire, shift_en, word_end, chain_full;
   logic pk_clear, pk_flush;

   assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
   assign load_fire  = (state == ST_LOAD) && s_valid;
   // Output backpressure freezes the chain so no tail bit is captured without room.
   assign shift_en   = (state == ST_SHIFT) && !(m_valid && !m_ready);
   assign bitcnt_inc = bitcnt + CNT_W'(1);
   assign shcnt_inc  = shcnt + SH_W'(1);
   assign chain_full = (bitcnt_inc == CNT_MAX);
   assign word_end   = shift_en && ((shcnt_inc == SH_MAX) || chain_full);

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state  <= ST_IDLE;
         bitcnt <= '0;
         shcnt  <= '0;
         word_q <= '0;
         last_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            bitcnt <= '0;
            shcnt  <= '0;
            word_q <= '0;
            last_q <= 1'b0;
         end else if (load_fire) begin
            word_q <= s_data;
            last_q <= s_last;
            shcnt  <= '0;
         end else if (shift_en) begin
            word_q <= {word_q[WORD_W-2:0], 1'b0};
            bitcnt <= bitcnt_inc;
            shcnt  <= shcnt_inc;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      s_ready      = 1'b0;
      chain_clk_en = 1'b0;
      ccff_head    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      pk_clear     = 1'b0;
      pk_flush     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LOAD;
               pk_clear  = 1'b1;
            end
         end
         ST_LOAD: begin
            busy    = 1'b1;
            s_ready = 1'b1;
            if (s_valid) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            busy         = 1'b1;
            chain_clk_en = shift_en;
            ccff_head    = shift_en && word_q[WORD_W-1];
            if (word_end) begin
               if (chain_full) state_nxt = last_q ? ST_DRAIN : ST_ERR;
               else            state_nxt = last_q ? ST_ERR : ST_LOAD;
               // Entering ERR drops any readback word still waiting for the host.
               if (state_nxt == ST_ERR) pk_clear = 1'b1;
            end
         end
         ST_DRAIN: begin
            busy     = 1'b1;
            pk_flush = 1'b1;
            if (m_valid && m_ready && m_last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt = ST_LOAD;
               pk_clear  = 1'b1;
            end
         end
         ST_ERR: begin
            err = 1'b1;
            if (start) begin
               state_nxt = ST_LOAD;
               pk_clear  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   ccff_rb_packer #(
      .WORD_W (WORD_W)
   ) u_packer (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .clear        (pk_clear),
      .cap_en       (shift_en),
      .cap_bit      (ccff_tail),
      .cap_final    (chain_full),
      .flush        (pk_flush),
      .m_ready      (m_ready),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_last       (m_last)
   );

endmodule

// File: tb/tb_ccff_chain_driver.sv
// Bench for ccff_chain_driver: 20-bit chain model on the head/tail pins, scoreboard
// queues for head bits and readback words, directed and randomized loads.
module tb_ccff_chain_driver;

   localparam int LEN = 20;
   localparam int W   = 8;

   logic           prog_clk = 1'b0;
   logic           prog_reset_n, start, s_valid, s_ready, s_last;
   logic [W-1:0]   s_data, m_data;
   logic           ccff_head, ccff_tail, chain_clk_en;
   logic           m_valid, m_ready, m_last, busy, done, err;

   logic [LEN-1:0] chain = '0;
   logic [LEN-1:0] pre_val = '0;
   logic           preload_req = 1'b0;

   int checks   = 0;
   int failures = 0;
   int shifts   = 0;
   int rdy_mode = 0;
   bit hold_done = 1'b0;

   logic       exp_head[$];
   logic [W:0] exp_rb[$];

   logic [W-1:0] wbuf[8];
   bit           lbuf[8];
   int           nwords = 0;

   ccff_chain_driver #(.CHAIN_LEN(LEN), .WORD_W(W)) dut (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .start        (start),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .ccff_head    (ccff_head),
      .ccff_tail    (ccff_tail),
      .chain_clk_en (chain_clk_en),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 prog_clk = ~prog_clk;

   // Physical chain: tail is the far end, head enters at bit 0.
   assign ccff_tail = chain[LEN-1];
   always @(posedge prog_clk) begin
      if (preload_req)       chain <= pre_val;
      else if (chain_clk_en) chain <= {chain[LEN-2:0], ccff_head};
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: unexpected event", nm);
   endtask

   // Monitor: head bits and readback words against the scoreboard queues.
   always @(negedge prog_clk) begin
      if (prog_reset_n) begin
         if (chain_clk_en) begin
            shifts++;
            if (exp_head.size() == 0) fail_now("head_extra");
            else chk("head_bit", 64'(ccff_head), 64'(exp_head.pop_front()));
         end else begin
            chk("head_zero_when_idle", 64'(ccff_head), 64'd0);
         end
         if (m_valid && m_ready) begin
            if (exp_rb.size() == 0) fail_now("rb_extra");
            else chk("rb_word", 64'({m_last, m_data}), 64'(exp_rb.pop_front()));
         end
      end
   end

   // m_ready driver: 0 = always ready, 1 = random, 2 = hold 5 cycles on first word.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge prog_clk); #1;
         case (rdy_mode)
            1: m_ready = ($urandom_range(0, 3) != 0);
            2: begin
               m_ready = 1'b1;
               if (m_valid && !hold_done) begin
                  hold_done = 1'b1;
                  m_ready   = 1'b0;
                  for (int i = 0; i < 5; i++) begin
                     @(negedge prog_clk);
                     chk("stall_clk_en", 64'(chain_clk_en), 64'd0);
                     @(posedge prog_clk); #1;
                  end
                  m_ready = 1'b1;
               end
            end
            default: m_ready = 1'b1;
         endcase
      end
   end

   task automatic check_all_zero(input string nm);
      chk(nm, 64'({ccff_head, chain_clk_en, s_ready, m_valid, m_data, m_last, busy, done, err}), 64'd0);
   endtask

   task automatic do_preload(input logic [LEN-1:0] p);
      pre_val     = p;
      preload_req = 1'b1;
      @(posedge prog_clk); #1;
      preload_req = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
   endtask

   task automatic feed_word(input int i, output bit ok);
      int cyc = 0;
      bit hs  = 1'b0;
      s_data  = wbuf[i];
      s_last  = lbuf[i];
      s_valid = 1'b1;
      while (!hs && cyc < 300) begin
         @(negedge prog_clk);
         hs = s_ready;
         @(posedge prog_clk); #1;
         cyc++;
      end
      s_valid = 1'b0;
      ok = hs;
      if (!hs) fail_now("s_handshake_timeout");
   endtask

   // Reference: bits are consumed MSB-first until the chain is full; the load ends
   // in error if the last flag and the full chain do not coincide.
   task automatic run_load(input logic [LEN-1:0] pre, input int mode, input bit poke);
      int             k = 0, nused = 0, na = 0, cyc = 0, base, n_err;
      bit             err_exp = 1'b0, ok;
      logic [LEN-1:0] exp_chain = pre;
      logic [W-1:0]   acc = '0;
      for (int i = 0; i < nwords && nused == 0; i++) begin
         for (int j = W - 1; j >= 0; j--) begin
            if (k < LEN) begin
               exp_head.push_back(wbuf[i][j]);
               exp_chain = {exp_chain[LEN-2:0], wbuf[i][j]};
               k++;
            end
         end
         if (k == LEN) begin
            err_exp = !lbuf[i];
            nused   = i + 1;
         end else if (lbuf[i]) begin
            err_exp = 1'b1;
            nused   = i + 1;
         end
      end
      if (nused == 0) nused = nwords;
      if (!err_exp) begin
         for (int b = LEN - 1; b >= 0; b--) begin
            acc[W-1-na] = pre[b];
            na++;
            if (na == W || b == 0) begin
               exp_rb.push_back({(b == 0), acc});
               acc = '0;
               na  = 0;
            end
         end
      end else begin
         for (int c = 0; c < (k - 1) / W; c++) exp_rb.push_back({1'b0, pre[LEN-1-c*W -: W]});
      end

      do_preload(pre);
      rdy_mode  = mode;
      hold_done = 1'b0;
      base      = shifts;
      pulse_start();
      for (int i = 0; i < nused; i++) begin
         if (poke && i == 1) begin
            cyc = 0;
            while (shifts - base < 3 && cyc < 200) begin
               @(posedge prog_clk); #1;
               cyc++;
            end
            chk("poke_in_shift", 64'(chain_clk_en), 64'd1);
            pulse_start();
         end
         feed_word(i, ok);
         if (!ok) break;
      end
      cyc = 0;
      while (!done && !err && cyc < 500) begin
         @(posedge prog_clk); #1;
         cyc++;
      end
      chk("end_done", 64'(done), 64'(!err_exp));
      chk("end_err", 64'(err), 64'(err_exp));
      chk("busy_at_end", 64'(busy), 64'd0);
      if (err_exp) begin
         n_err = shifts;
         repeat (10) begin
            @(posedge prog_clk); #1;
         end
         chk("no_shift_after_err", 64'(shifts), 64'(n_err));
         chk("m_valid_in_err", 64'(m_valid), 64'd0);
         chk("s_ready_in_err", 64'(s_ready), 64'd0);
      end
      chk("shift_count", 64'(shifts - base), 64'(k));
      chk("final_chain", 64'(chain), 64'(exp_chain));
      chk("head_queue_empty", 64'(exp_head.size()), 64'd0);
      chk("rb_queue_empty", 64'(exp_rb.size()), 64'd0);
      exp_head.delete();
      exp_rb.delete();
      rdy_mode = 0;
   endtask

   task automatic set_words(input logic [W-1:0] a, b, c, input bit la, lb, lc);
      wbuf[0] = a; wbuf[1] = b; wbuf[2] = c;
      lbuf[0] = la; lbuf[1] = lb; lbuf[2] = lc;
      nwords = 3;
   endtask

   initial begin
      int  cyc, base;
      bit  ok;
      prog_reset_n = 1'b0;
      start        = 1'b0;
      s_valid      = 1'b0;
      s_data       = '0;
      s_last       = 1'b0;
      repeat (3) @(posedge prog_clk);
      #1;
      check_all_zero("reset_outputs");
      prog_reset_n = 1'b1;
      @(posedge prog_clk); #1;

      // s_valid together with start in IDLE must not transfer the junk word.
      s_data  = 8'hFF;
      s_valid = 1'b1;
      start   = 1'b1;
      @(negedge prog_clk);
      chk("s_ready_in_idle", 64'(s_ready), 64'd0);
      @(posedge prog_clk); #1;
      start   = 1'b0;
      s_valid = 1'b0;
      set_words(8'h12, 8'h34, 8'h5F, 1'b0, 1'b0, 1'b1);
      run_load(20'hABCDE, 0, 1'b0);

      // Same load with a 5-cycle stall after the first readback word.
      run_load(20'hABCDE, 2, 1'b0);

      // Early last flag on the second word.
      set_words(8'h12, 8'h34, 8'h5F, 1'b0, 1'b1, 1'b0);
      run_load(20'hABCDE, 0, 1'b0);

      // Chain fills without a last flag.
      set_words(8'h12, 8'h34, 8'h5F, 1'b0, 1'b0, 1'b0);
      run_load(20'h13579, 0, 1'b0);

      // start pulsed mid-shift is ignored.
      set_words(8'hA5, 8'h3C, 8'h90, 1'b0, 1'b0, 1'b1);
      run_load(20'h0F0F0, 0, 1'b1);

      // Reset asserted during the 9th shift, then a full load recovers.
      set_words(8'h12, 8'h34, 8'h5F, 1'b0, 1'b0, 1'b1);
      for (int j = W - 1; j >= 0; j--) exp_head.push_back(wbuf[0][j]);
      for (int j = W - 1; j >= 0; j--) exp_head.push_back(wbuf[1][j]);
      exp_rb.push_back({1'b0, 8'hAB});
      do_preload(20'hABCDE);
      base = shifts;
      pulse_start();
      feed_word(0, ok);
      feed_word(1, ok);
      cyc = 0;
      while (!(chain_clk_en && (shifts - base == 8)) && cyc < 100) begin
         @(posedge prog_clk); #1;
         cyc++;
      end
      chk("at_9th_shift", 64'(shifts - base), 64'd8);
      #2;
      prog_reset_n = 1'b0;
      #1;
      check_all_zero("mid_load_reset_outputs");
      exp_head.delete();
      exp_rb.delete();
      repeat (2) @(posedge prog_clk);
      #1;
      prog_reset_n = 1'b1;
      run_load(20'hABCDE, 0, 1'b0);

      // Randomized loads: random backpressure on good loads, random last flags otherwise.
      for (int r = 0; r < 10; r++) begin
         set_words(W'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b1);
         if (r >= 6) begin
            lbuf[0] = ($urandom_range(0, 3) == 0);
            lbuf[1] = ($urandom_range(0, 1) == 0);
            lbuf[2] = ($urandom_range(0, 1) == 0);
         end
         run_load(LEN'($urandom), (r < 6) ? 1 : 0, (r == 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ccff_chain_driver.md
CCFF_CHAIN_DRIVER -- requirements
Module: ccff_chain_driver

Interface
REQ-001 Parameter CHAIN_LEN, default 160; number of configuration flip-flops in the target ccff chain, minimum 1.
REQ-002 Parameter WORD_W, default 8; host word width in bits, minimum 2.
REQ-003 prog_clk  in  1  the block's only clock; all state updates on its rising edge.
REQ-004 prog_reset_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
REQ-006 s_valid / s_ready / s_data[WORD_W] / s_last  in/out/in/in  bitstream word input; transfer when s_valid and s_ready are both 1.
REQ-007 ccff_head  out  1  serial configuration bit driven into the chain head.
REQ-008 ccff_tail  in  1  serial bit returned from the chain tail.
REQ-009 chain_clk_en  out  1  shift enable for the external prog_clk gate; the chain advances one bit per cycle in which it is 1.
REQ-010 m_valid / m_ready / m_data[WORD_W] / m_last  out/in/out/out  readback word output carrying the previous chain contents.
REQ-011 busy, done, err  out  1 each  status flags.

Function
REQ-012 The state machine SHALL have the states IDLE, LOAD, SHIFT, DRAIN, DONE and ERR.
REQ-013 start in IDLE, DONE or ERR SHALL clear the bit counter, readback buffer, done and err, and enter LOAD on the next cycle; start in any other state is ignored.
REQ-014 s_ready SHALL be 1 only in LOAD; an accepted word is latched together with s_last, and the state moves to SHIFT on the next cycle.
REQ-015 In SHIFT, chain_clk_en = NOT (m_valid AND NOT m_ready); output backpressure stalls the chain with no bit lost.
REQ-016 On each enabled SHIFT cycle: ccff_head = the current MSB of the latched word, ccff_tail is sampled into the readback buffer, the word shifts left by 1, and bitcnt increments.
REQ-017 ccff_head SHALL be 0 whenever chain_clk_en = 0.
REQ-018 Word end is reached after WORD_W shifts, or when bitcnt reaches CHAIN_LEN; at bitcnt = CHAIN_LEN the unshifted bits of that word are discarded.
REQ-019 At word end:
  - bitcnt = CHAIN_LEN with the latched s_last = 1 -> DRAIN.
  - bitcnt = CHAIN_LEN with s_last = 0 -> ERR.
  - bitcnt < CHAIN_LEN with s_last = 1 -> ERR.
  - Otherwise -> LOAD.
REQ-020 bitcnt width SHALL be clog2(CHAIN_LEN+1); the counter never wraps.
REQ-021 Readback packing:
  - The first captured tail bit is placed in the m_data MSB.
  - m_valid asserts the cycle after the WORD_W-th capture.
  - m_data and m_valid are held until m_ready.
REQ-022 In DRAIN:
  - A partial readback word is emitted with its unfilled LSBs set to 0 and m_last = 1.
  - If the final word is full, that word carries m_last = 1.
  - DONE is entered the cycle after the m_last handshake.
REQ-023 busy SHALL be 1 in LOAD, SHIFT and DRAIN; done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-024 In ERR, chain_clk_en = 0, s_ready = 0 and m_valid = 0; any pending readback word is dropped.
REQ-025 A cycle with both s_valid and start in IDLE SHALL NOT transfer a word (s_ready = 0 in IDLE).

Reset
REQ-026 While prog_reset_n = 0, in any state:
  - state = IDLE;
  - bitcnt = 0; buffers = 0;
  - ccff_head = 0, chain_clk_en = 0, s_ready = 0;
  - m_valid = 0, m_data = 0, m_last = 0;
  - busy = done = err = 0.
REQ-027 Reset asserted mid-load SHALL stop shifting immediately (asynchronously); the chain contents are then undefined, and recovery requires a new start.

Structure
REQ-028 A shared package ccff_pkg SHALL hold the state encoding constants and the CHAIN_LEN/WORD_W defaults.
REQ-029 The readback packer SHALL be a sub-module named ccff_rb_packer (serial-in, word-out, valid/ready, zero-pad flush).

Verification
REQ-030 Use CHAIN_LEN=20, WORD_W=8, with a 20-bit chain model preloaded to 0xABCDE.
  - Stimulus: send words 0x12, 0x34, 0x5F (last) with no backpressure.
  - Required: head sequence 0x12345 MSB-first over 20 enabled cycles.
  - Required: readback 0xAB, 0xCD, 0xE0 with m_last on the third word.
  - Required: done = 1.
REQ-031 Hold m_ready = 0 for 5 cycles after the first readback word.
  - Required: chain_clk_en = 0 for those 5 cycles.
  - Required: final chain contents are identical to the no-backpressure run.
REQ-032 Set s_last on the second word.
  - Required: ERR after the 16th shift, err = 1, and no further chain_clk_en.
REQ-033 Send three words with s_last = 0.
  - Required: ERR at bitcnt = 20.
REQ-034 Assert prog_reset_n = 0 at the 9th shift.
  - Required: all outputs are 0 in the same cycle.
  - Required: a subsequent start with a full load succeeds.
REQ-035 Pulse start in SHIFT.
  - Required: it is ignored, and the bit count and data are unaffected.
